// File: rtl/cadence_gen.sv
// Pedal-cadence sensor emulator: turns an 8-bit cadence period code into a
// 50%-duty cadence waveform with a one-clock rise strobe and a rise counter.
// The period encoding matches the cadence measurement path, so a code written
// here is read back unchanged by the measurement block.
module cadence_gen #(
    parameter int unsigned FAST_SIM = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       per_vld,
    input  logic [7:0] per_in,
    output logic       per_ack,
    output logic       cadence,
    output logic       cadence_rise,
    output logic [7:0] rev_cnt,
    output logic [7:0] active_per
);

    localparam int unsigned SH       = (FAST_SIM != 0) ? 7 : 16;
    localparam logic [7:0]  NO_PEDAL = 8'hE4;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] tmr_q, tmr_d;
    logic        cadence_q, cadence_d;
    logic        cadence_rise_q, cadence_rise_d;
    logic        per_ack_q, per_ack_d;
    logic [7:0]  rev_cnt_q, rev_cnt_d;
    logic [7:0]  active_per_q, active_per_d;
    logic [7:0]  pending_q, pending_d;
    logic        pend_flag_q, pend_flag_d;

    logic [23:0] per_clks;
    logic [23:0] t_hi;
    logic [23:0] t_lo;
    logic        lo_done;
    logic        boundary;
    logic        apply;
    logic [7:0]  new_code;
    logic [7:0]  code;
    logic        run_ok;
    logic        start;

    // Mid-bin period of the active code and its high/low split.
    always_comb begin
        per_clks = ({16'd0, active_per_q} << SH) | (24'd1 << (SH - 1));
        t_hi     = per_clks >> 1;
        t_lo     = per_clks - t_hi;
    end

    // Period-code hand-off and FSM next state; a strobe landing on a boundary
    // bypasses the pending register so it takes effect at that same boundary.
    always_comb begin
        state_d        = state_q;
        tmr_d          = tmr_q;
        cadence_rise_d = 1'b0;
        per_ack_d      = 1'b0;
        rev_cnt_d      = rev_cnt_q;
        active_per_d   = active_per_q;
        pending_d      = pending_q;
        pend_flag_d    = pend_flag_q;
        start          = 1'b0;

        lo_done  = (state_q == LOW) && (tmr_q == t_lo - 24'd1);
        boundary = (state_q == IDLE) || lo_done;
        apply    = boundary && (per_vld || pend_flag_q);
        new_code = per_vld ? per_in : pending_q;
        code     = apply ? new_code : active_per_q;
        run_ok   = en && (code < NO_PEDAL);

        if (apply) begin
            active_per_d = new_code;
            pending_d    = new_code;
            pend_flag_d  = 1'b0;
            per_ack_d    = 1'b1;
        end else if (per_vld) begin
            pending_d    = per_in;
            pend_flag_d  = 1'b1;
        end

        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (run_ok) begin
                    state_d = HIGH;
                    start   = 1'b1;
                end
            end
            HIGH: begin
                if (!en) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else if (tmr_q == t_hi - 24'd1) begin
                    state_d = LOW;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 24'd1;
                end
            end
            LOW: begin
                if (lo_done) begin
                    tmr_d = '0;
                    if (run_ok) begin
                        state_d = HIGH;
                        start   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!en) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 24'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        endcase

        if (start) begin
            cadence_rise_d = 1'b1;
            rev_cnt_d      = rev_cnt_q + 8'd1;
        end
        cadence_d = (state_d == HIGH);
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            tmr_q          <= '0;
            cadence_q      <= 1'b0;
            cadence_rise_q <= 1'b0;
            per_ack_q      <= 1'b0;
            rev_cnt_q      <= '0;
            active_per_q   <= NO_PEDAL;
            pending_q      <= NO_PEDAL;
            pend_flag_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmr_q          <= tmr_d;
            cadence_q      <= cadence_d;
            cadence_rise_q <= cadence_rise_d;
            per_ack_q      <= per_ack_d;
            rev_cnt_q      <= rev_cnt_d;
            active_per_q   <= active_per_d;
            pending_q      <= pending_d;
            pend_flag_q    <= pend_flag_d;
        end
    end

    assign per_ack      = per_ack_q;
    assign cadence      = cadence_q;
    assign cadence_rise = cadence_rise_q;
    assign rev_cnt      = rev_cnt_q;
    assign active_per   = active_per_q;

endmodule
